iir_coeff_sequencer: RTL
========================

Name: iir_coeff_sequencer

Overview:
Timing and coefficient controller for the stereo 3-tap IIR filter used in the audio path. It generates the filter's `ce` and `sample_ce` strobes from a free-running sample-period counter. It holds a shadow copy of the runtime coefficient set, written over a simple register-write handshake. It commits that set atomically at a sample boundary, optionally flushing the filter state. It drives the filter's `cx/cx0..2/cy0..2` inputs directly, with the filter instantiated with `use_params=0`.

Parameters:
- SAMPLE_DIV, 1125, clocks per output sample period (54 MHz / 48 kHz); must exceed (CE_PER_SAMPLE-1)*CE_SPACING+1.
- CE_PER_SAMPLE, 2, ce pulses per sample period; must be even (stereo channel parity).
- CE_SPACING, 2, clocks between successive ce pulses; minimum 1.
- CNT_W, 16, width of the period counter; 2^CNT_W must be at least SAMPLE_DIV.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- run  in  1  1 = sequencing enabled
- wr_en  in  1  write request
- wr_addr  in  3  register address: 0 cx, 1 cx0, 2 cx1, 3 cx2, 4 cy0, 5 cy1, 6 cy2, 7 control
- wr_data  in  40  write data, LSB-aligned
- wr_ready  out  1  write accepted when wr_en & wr_ready
- commit_done  out  1  one-cycle pulse when the shadow set becomes active
- ce  out  1  filter compute strobe
- sample_ce  out  1  filter output-latch strobe
- flt_reset  out  1  active-high filter state clear
- cx  out  40  active input gain
- cx0, cx1, cx2  out  8  active feed-forward shift codes
- cy0, cy1, cy2  out  24  active feedback coefficients

Behaviour:
- Reset (reset_n=0, async):
  - Counter p=0; stopped state.
  - All outputs 0 except wr_ready=1.
  - Active and shadow registers 0, which gives a silent filter.
  - pending=0.
- States: STOP and RUN.
  - STOP→RUN when run=1; that cycle is p=0.
  - RUN→STOP only at p=SAMPLE_DIV-1 with run=0, so a period is never truncated and ch parity is preserved.
  - In STOP, p holds 0 and ce=sample_ce=0.
- Counter: in RUN, p increments each cycle and wraps from SAMPLE_DIV-1 to 0.
- Strobes:
  - All strobes are registered and are single-cycle pulses.
  - ce=1 at p = k*CE_SPACING for k=0..CE_PER_SAMPLE-1.
  - sample_ce=1 at p=SAMPLE_DIV-1.
- Writes:
  - Accepted when wr_en & wr_ready.
  - Addresses 0-6 load the shadow register from the low bits of wr_data.
  - Address 7 with wr_data[0]=1 sets pending=1 and latches flush=wr_data[1]. Address 7 with wr_data[0]=0 is a no-op.
  - wr_ready = ~pending. Writes presented while wr_ready=0 are dropped; the requester holds wr_en until accepted.
- Commit:
  - In RUN with pending=1, at the wrap from p=SAMPLE_DIV-1 to p=0: active <= shadow and pending <= 0. In the cycle at p=0, commit_done=1 and the new coefficients are visible.
  - A commit request accepted in the cycle p=SAMPLE_DIV-1 waits for the next boundary.
  - In STOP with pending=1: commit one cycle after the request is accepted, with commit_done pulsing on that cycle.
- Flush:
  - If the latched flush=1, flt_reset=1 for exactly the commit_done cycle.
  - In RUN, all CE_PER_SAMPLE ce pulses of that period are suppressed. sample_ce still fires.
- Simultaneous events:
  - A write to addresses 0-6 in the same cycle as the commit cannot occur, because wr_ready=0.
  - run falling with pending=1: the commit still applies at the final boundary.
- Reset mid-operation: shadow, active and pending are all cleared. A pending commit is lost.

Test Plan:
- SAMPLE_DIV=8, CE_SPACING=2, CE_PER_SAMPLE=2, run=1 after reset → ce at p=0,2 and sample_ce at p=7, repeating every 8 clocks; no other strobes.
- Write cx=40'h0000410000 and cy0=24'hA11B2C, then addr7 data=1 at p=3 → wr_ready=0 from the next cycle; at next p=0, cx and cy0 update and commit_done=1 together; wr_ready=1 from the following cycle.
- Commit with data=3 (flush) → flt_reset=1 for one cycle at p=0, no ce in that period, ce resumes at p=0 of the following period; sample_ce is unaffected.
- Write cx1=8'h83 while pending=1 → write is dropped and shadow is unchanged; a retry after commit_done is accepted.
- Drop run at p=4 → strobes continue through p=7 and stop afterwards. A commit while stopped → cy2 updates and commit_done pulses 1 cycle after acceptance.
- Assert reset_n=0 at p=5 with a commit pending → all outputs 0 immediately, wr_ready=1, no commit_done after release.

Source files
------------

// File: rtl/iir_coeff_sequencer.sv
// Strobe timing and atomic coefficient commit for the stereo 3-tap IIR.
// Shadow set is written over wr_*, then swapped in at a sample boundary.
module iir_coeff_sequencer #(
  parameter int SAMPLE_DIV    = 1125,
  parameter int CE_PER_SAMPLE = 2,
  parameter int CE_SPACING    = 2,
  parameter int CNT_W         = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [39:0] wr_data,
  output logic        wr_ready,
  output logic        commit_done,
  output logic        ce,
  output logic        sample_ce,
  output logic        flt_reset,
  output logic [39:0] cx,
  output logic [7:0]  cx0,
  output logic [7:0]  cx1,
  output logic [7:0]  cx2,
  output logic [23:0] cy0,
  output logic [23:0] cy1,
  output logic [23:0] cy2
);

  typedef enum logic {ST_STOP, ST_RUN} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_DIV - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] p_q, p_d;
  logic             pending_q, flush_q;
  logic             mute_q, mute_d;

  logic [39:0] sh_cx;
  logic [7:0]  sh_cx0, sh_cx1, sh_cx2;
  logic [23:0] sh_cy0, sh_cy1, sh_cy2;

  logic accept, ctl_req, wrap, commit;
  logic flush_sel, hit;

  assign wr_ready = ~pending_q;

  always_comb begin
    accept    = wr_en & ~pending_q;
    ctl_req   = accept && (wr_addr == 3'd7) && wr_data[0];
    wrap      = (state_q == ST_RUN) && (p_q == LAST);
    state_d   = state_q;
    unique case (state_q)
      ST_STOP: if (run) state_d = ST_RUN;
      ST_RUN:  if (wrap && !run) state_d = ST_STOP;
      default: state_d = ST_STOP;
    endcase
    p_d = '0;
    if (state_q == ST_RUN && state_d == ST_RUN && !wrap)
      p_d = p_q + CNT_W'(1);
    // A stopped sequencer has no boundary to wait for.
    commit    = (wrap && pending_q) ||
                (state_q == ST_STOP && (pending_q || ctl_req));
    flush_sel = pending_q ? flush_q : wr_data[1];
    mute_d    = mute_q;
    if (commit)
      mute_d = flush_sel && (state_d == ST_RUN);
    else if (wrap)
      mute_d = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < CE_PER_SAMPLE; k++)
      if (p_d == CNT_W'(k * CE_SPACING)) hit = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_STOP;
      p_q         <= '0;
      mute_q      <= 1'b0;
      pending_q   <= 1'b0;
      flush_q     <= 1'b0;
      ce          <= 1'b0;
      sample_ce   <= 1'b0;
      commit_done <= 1'b0;
      flt_reset   <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      mute_q      <= mute_d;
      ce          <= (state_d == ST_RUN) && hit && !mute_d;
      sample_ce   <= (state_d == ST_RUN) && (p_d == LAST);
      commit_done <= commit;
      flt_reset   <= commit && flush_sel;
      if (commit) begin
        pending_q <= 1'b0;
      end else if (ctl_req && state_q == ST_RUN) begin
        pending_q <= 1'b1;
        flush_q   <= wr_data[1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_cx  <= '0;
      sh_cx0 <= '0;
      sh_cx1 <= '0;
      sh_cx2 <= '0;
      sh_cy0 <= '0;
      sh_cy1 <= '0;
      sh_cy2 <= '0;
    end else if (accept) begin
      unique case (wr_addr)
        3'd0: sh_cx  <= wr_data;
        3'd1: sh_cx0 <= wr_data[7:0];
        3'd2: sh_cx1 <= wr_data[7:0];
        3'd3: sh_cx2 <= wr_data[7:0];
        3'd4: sh_cy0 <= wr_data[23:0];
        3'd5: sh_cy1 <= wr_data[23:0];
        3'd6: sh_cy2 <= wr_data[23:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cx  <= '0;
      cx0 <= '0;
      cx1 <= '0;
      cx2 <= '0;
      cy0 <= '0;
      cy1 <= '0;
      cy2 <= '0;
    end else if (commit) begin
      cx  <= sh_cx;
      cx0 <= sh_cx0;
      cx1 <= sh_cx1;
      cx2 <= sh_cx2;
      cy0 <= sh_cy0;
      cy1 <= sh_cy1;
      cy2 <= sh_cy2;
    end
  end

endmodule
